// File: rtl/router_pkg.sv
// Shared state encoding, port address constants and flag-select helper
// for the 1x3 router packet-control FSM.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL          = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;

  localparam logic [1:0] PORT0        = 2'd0;
  localparam logic [1:0] PORT1        = 2'd1;
  localparam logic [1:0] PORT2        = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  // Pick the per-port flag addressed by addr; the invalid address selects nothing.
  function automatic logic port_sel(input logic [2:0] flags, input logic [1:0] addr);
    logic sel;
    case (addr)
      PORT0:        sel = flags[0];
      PORT1:        sel = flags[1];
      PORT2:        sel = flags[2];
      ADDR_INVALID: sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-control FSM of the 1x3 router: decodes the header address, sequences
// header/payload/parity loading and stalls on a full destination FIFO.
module router_fsm
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_rst_0,
  input  logic       soft_rst_1,
  input  logic       soft_rst_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [2:0] fifo_empty;
  logic [2:0] soft_rst;

  assign fifo_empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_rst   = {soft_rst_2, soft_rst_1, soft_rst_0};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          addr_d = data_in;
          if (data_in != ADDR_INVALID)
            state_d = port_sel(fifo_empty, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL: begin
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL : DECODE_ADDRESS;
      WAIT_TILL_EMPTY: begin
        if (port_sel(fifo_empty, addr_q)) state_d = LOAD_FIRST_DATA;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    // Read-timeout soft reset of the addressed port aborts the packet from any busy state.
    if (state_q != DECODE_ADDRESS && port_sel(soft_rst, addr_q))
      state_d = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    full_state    = (state_q == FIFO_FULL);
    write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                    (state_q == LOAD_AFTER_FULL);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: walks each packet scenario and compares the
// full output vector against the hand-derived per-state decode every cycle.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_rst_0, soft_rst_1, soft_rst_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Output vector: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0001;
  localparam logic [7:0] O_LD  = 8'b0010_0100;
  localparam logic [7:0] O_LAF = 8'b0001_0101;
  localparam logic [7:0] O_FF  = 8'b0000_1001;
  localparam logic [7:0] O_LP  = 8'b0000_0101;
  localparam logic [7:0] O_CPE = 8'b0000_0011;
  localparam logic [7:0] O_WTE = 8'b0000_0001;

  logic [7:0] outs;
  assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                 write_enb_reg, rst_int_reg, busy};

  always #5 clk = ~clk;

  router_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_rst_0    (soft_rst_0),
    .soft_rst_1    (soft_rst_1),
    .soft_rst_2    (soft_rst_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one clock edge with the current inputs, then compare away from the edge.
  task automatic tick(input string tag, input logic [7:0] exp);
    @(posedge clk);
    #1;
    check_eq(tag, outs, exp);
  endtask

  initial begin
    rst = 1'b0; pkt_valid = 1'b0; data_in = '0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_rst_0 = 1'b0; soft_rst_1 = 1'b0; soft_rst_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;

    tick("reset_c1", O_DA);
    tick("reset_c2", O_DA);
    rst = 1'b1;

    // Clean packet to port 1, header 0x05, pkt_valid for 4 edges
    pkt_valid = 1'b1; data_in = 2'd1;
    tick("p1_lfd", O_LFD);
    tick("p1_ld1", O_LD);
    tick("p1_ld2", O_LD);
    tick("p1_ld3", O_LD);
    pkt_valid = 1'b0;
    tick("p1_lp", O_LP);
    tick("p1_cpe", O_CPE);
    tick("p1_da", O_DA);

    // Busy destination: port 2 not empty
    fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'd2;
    for (int i = 0; i < 5; i++) tick("p2_wait", O_WTE);
    fifo_empty_2 = 1'b1;
    tick("p2_lfd", O_LFD);
    tick("p2_ld", O_LD);
    pkt_valid = 1'b0;
    tick("p2_lp", O_LP);
    tick("p2_cpe", O_CPE);
    tick("p2_da", O_DA);

    // Full stall, fifo_full and pkt_valid falling in the same LOAD_DATA cycle
    pkt_valid = 1'b1; data_in = 2'd0;
    tick("st_lfd", O_LFD);
    tick("st_ld", O_LD);
    fifo_full = 1'b1; pkt_valid = 1'b0;
    tick("st_full1", O_FF);
    tick("st_full2", O_FF);
    tick("st_full3", O_FF);
    fifo_full = 1'b0; low_pkt_valid = 1'b1;
    tick("st_laf", O_LAF);
    tick("st_lp", O_LP);
    low_pkt_valid = 1'b0;
    fifo_full = 1'b1;
    tick("st_cpe", O_CPE);
    tick("st_cpe_full", O_FF);
    fifo_full = 1'b0; parity_done = 1'b1;
    tick("st_laf2", O_LAF);
    tick("st_laf_pdone", O_DA);
    parity_done = 1'b0;

    // LOAD_AFTER_FULL returning to LOAD_DATA when neither flag is set
    pkt_valid = 1'b1; data_in = 2'd1;
    tick("rl_lfd", O_LFD);
    fifo_full = 1'b1;
    tick("rl_ld", O_LD);
    tick("rl_full", O_FF);
    fifo_full = 1'b0;
    tick("rl_laf", O_LAF);
    tick("rl_ld_again", O_LD);
    pkt_valid = 1'b0;
    tick("rl_lp", O_LP);
    tick("rl_cpe", O_CPE);
    tick("rl_da", O_DA);

    // Soft reset: non-addressed port ignored, addressed port aborts
    pkt_valid = 1'b1; data_in = 2'd0;
    tick("sr_lfd", O_LFD);
    tick("sr_ld", O_LD);
    soft_rst_1 = 1'b1;
    tick("sr_other_port", O_LD);
    soft_rst_1 = 1'b0; soft_rst_0 = 1'b1;
    tick("sr_own_port", O_DA);
    soft_rst_0 = 1'b0; pkt_valid = 1'b0;
    tick("sr_idle", O_DA);

    // Synchronous reset mid-packet
    pkt_valid = 1'b1; data_in = 2'd2;
    tick("mr_lfd", O_LFD);
    tick("mr_ld", O_LD);
    rst = 1'b0;
    tick("mr_reset", O_DA);
    rst = 1'b1; pkt_valid = 1'b0;
    tick("mr_idle", O_DA);

    // Invalid address 3 never leaves DECODE_ADDRESS
    pkt_valid = 1'b1; data_in = 2'd3;
    for (int i = 0; i < 4; i++) tick("inv_addr", O_DA);
    pkt_valid = 1'b0;
    tick("inv_idle", O_DA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
# router_fsm

Packet-control state machine of the 1x3 router. It sits directly upstream of the three per-port output FIFOs and the input register/parity block. It decodes the header address, sequences header, payload and parity loading, and stalls on a full destination FIFO. It also generates `lfd_state`, which the FIFO delays by one cycle internally to tag the header word, and the write-enable that the synchronizer steers to the addressed FIFO.

## Interface
Parameters:
- none; state encoding and address constants come from `router_pkg`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `pkt_valid`  in  1  input packet byte valid; high from header through last payload byte
- `data_in`  in  2  header bits [1:0] = destination port, 0..2; 3 is invalid
- `fifo_full`  in  1  full flag of the currently addressed FIFO, from the synchronizer
- `fifo_empty_0` / `fifo_empty_1` / `fifo_empty_2`  in  1 each  per-FIFO empty flags
- `soft_rst_0` / `soft_rst_1` / `soft_rst_2`  in  1 each  per-FIFO read-timeout soft resets
- `parity_done`  in  1  register block has captured the parity byte
- `low_pkt_valid`  in  1  `pkt_valid` fell while the FSM was in FIFO_FULL
- `detect_add`  out  1  high in DECODE_ADDRESS
- `lfd_state`  out  1  high in LOAD_FIRST_DATA
- `ld_state`  out  1  high in LOAD_DATA
- `laf_state`  out  1  high in LOAD_AFTER_FULL
- `full_state`  out  1  high in FIFO_FULL
- `write_enb_reg`  out  1  high in LOAD_DATA, LOAD_PARITY or LOAD_AFTER_FULL
- `rst_int_reg`  out  1  high in CHECK_PARITY_ERROR
- `busy`  out  1  low only in DECODE_ADDRESS and LOAD_DATA

## Operation
- Eight states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- Address latch `addr_q[1:0]` loads `data_in` when the FSM is in DECODE_ADDRESS and `pkt_valid` = 1.
- Transitions:
  - DECODE_ADDRESS:
    - `pkt_valid` and `data_in` = k (0..2) and `fifo_empty_k` → LOAD_FIRST_DATA.
    - `pkt_valid` and `data_in` = k and not `fifo_empty_k` → WAIT_TILL_EMPTY.
    - Otherwise, including address 3 → stay.
  - LOAD_FIRST_DATA → LOAD_DATA, unconditionally.
  - LOAD_DATA:
    - `fifo_full` → FIFO_FULL.
    - Else not `pkt_valid` → LOAD_PARITY.
    - Else stay.
  - FIFO_FULL: not `fifo_full` → LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL:
    - `parity_done` → DECODE_ADDRESS.
    - Else `low_pkt_valid` → LOAD_PARITY.
    - Else → LOAD_DATA.
  - LOAD_PARITY → CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: `fifo_full` → FIFO_FULL; else → DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: `fifo_empty[addr_q]` → LOAD_FIRST_DATA; else stay.
- Soft reset: `soft_rst[addr_q]` asserted in any state other than DECODE_ADDRESS → DECODE_ADDRESS next cycle.
  - It overrides all other transitions.
  - Soft resets of non-addressed ports are ignored.
- Outputs are pure Moore decodes of the state register, so they carry no combinational input paths.

## Timing
- Reset (`rst` = 0 at a `clk` edge):
  - State = DECODE_ADDRESS and `addr_q` = 0.
  - Outputs: `detect_add` = 1; every other output = 0.
- All transitions take effect on the `clk` edge following the qualifying inputs; decisions have one cycle of latency.
- `lfd_state` is high for exactly one cycle per packet. The header byte reaches the FIFO on the next cycle (first `write_enb_reg` cycle), aligned by the FIFO's one-cycle `lfd_state` delay.
- Minimum packet, with the FIFO never full:
  - DECODE_ADDRESS → LOAD_FIRST_DATA → LOAD_DATA (≥1 cycle) → LOAD_PARITY → CHECK_PARITY_ERROR → DECODE_ADDRESS.
  - `busy` is low in DECODE_ADDRESS and LOAD_DATA only.
- `fifo_full` and `pkt_valid` fall in the same LOAD_DATA cycle: `fifo_full` wins (FIFO_FULL). Parity is then reached via LOAD_AFTER_FULL using `low_pkt_valid`.
- `rst` low mid-packet: state returns to DECODE_ADDRESS on that edge regardless of inputs.

## Structure
- `router_pkg`:
  - State enum, 3-bit binary encoding, DECODE_ADDRESS = 0.
  - Port address constants PORT0..PORT2 and ADDR_INVALID = 3.
- Single module holding three processes: state register plus `addr_q`, next-state logic, output decode. No sub-module.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles → `detect_add` = 1, `busy` = 0, all other outputs 0.
- Clean packet to port 1 with all FIFOs empty:
  - Stimulus: `pkt_valid` high 4 cycles, header 0x05.
  - Response: `lfd_state` pulses once; `ld_state` for 3 cycles; `write_enb_reg` spans LOAD_DATA and LOAD_PARITY; one `rst_int_reg` pulse; back to DECODE_ADDRESS.
- Busy destination:
  - Stimulus: header to port 2 with `fifo_empty_2` = 0 for 5 cycles.
  - Response: WAIT_TILL_EMPTY, `busy` = 1 throughout; one cycle after `fifo_empty_2` rises, `lfd_state` = 1.
- Full stall:
  - Stimulus: `fifo_full` = 1 during LOAD_DATA for 3 cycles, then 0 with `low_pkt_valid` = 1.
  - Response: `full_state` high 3 cycles → `laf_state` 1 cycle → LOAD_PARITY.
- Soft reset: `soft_rst_0` pulse during LOAD_DATA for a port-0 packet → DECODE_ADDRESS next cycle. A `soft_rst_1` pulse in the same scenario has no effect.
- Invalid address: header 0x03 with `pkt_valid` = 1 → state stays DECODE_ADDRESS and `lfd_state` never asserts.
